// File: rtl/dec_to_xs3_key_encoder.sv
// Debounced decimal-to-excess-3 keypad encoder.
// Ten active-low key lines pass through a two-flop synchronizer. The highest
// pressed key is debounced by a small press/release FSM, and each keystroke
// is delivered once as an excess-3 code through a VALID/READY holding register.
//
// Ports
//   CLK    in   1   clock, rising edge
//   RST    in   1   synchronous active-high reset
//   I_N    in  10   key lines, bit n low = key n pressed (asynchronous)
//   Q      out  4   excess-3 code {D,C,B,A} = n+3, stable while VALID
//   VALID  out  1   Q holds an undelivered code
//   READY  in   1   consumer takes Q on an edge with VALID && READY
//   OVF    out  1   sticky: a press was accepted while the holding register was full
//   BUSY   out  1   FSM is not idle
module dec_to_xs3_key_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4  // legal range 2..255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] I_N,
  output logic [3:0] Q,
  output logic       VALID,
  input  logic       READY,
  output logic       OVF,
  output logic       BUSY
);

  localparam int unsigned KEY_W = 10;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] XS3_OFFSET = IDX_W'(3);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [KEY_W-1:0] sync1_n, sync2_n;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] key, key_d;
  logic [IDX_W-1:0] cand;
  logic             key_present;
  logic             accept;
  logic [3:0]       q_d;
  logic             valid_d, ovf_d, busy_d;

  // Priority resolve: ascending scan so the highest low bit wins.
  always_comb begin
    cand        = '0;
    key_present = 1'b0;
    for (int i = 0; i < KEY_W; i++) begin
      if (!sync2_n[i]) begin
        cand        = IDX_W'(i);
        key_present = 1'b1;
      end
    end
  end

  // Next-state, debounce counter and holding-register update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    key_d   = key;
    accept  = 1'b0;
    q_d     = Q;
    valid_d = VALID;
    ovf_d   = OVF;

    unique case (state)
      IDLE: begin
        if (key_present) begin
          state_d = DEBOUNCE;
          key_d   = cand;
          cnt_d   = CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!key_present) begin
          state_d = IDLE;
        end else if (cand != key) begin
          key_d = cand;
          cnt_d = CNT_W'(1);
        end else if (cnt == CNT_LAST) begin
          accept  = 1'b1;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!key_present) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE: begin
        if (key_present) begin
          state_d = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-edge transfer frees the holding register for the new code.
    if (accept) begin
      if (!VALID || READY) begin
        q_d     = key + XS3_OFFSET;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (VALID && READY) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      key     <= '0;
      sync1_n <= '1;
      sync2_n <= '1;
      Q       <= '0;
      VALID   <= 1'b0;
      OVF     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      key     <= key_d;
      sync1_n <= I_N;
      sync2_n <= sync1_n;
      Q       <= q_d;
      VALID   <= valid_d;
      OVF     <= ovf_d;
      BUSY    <= busy_d;
    end
  end

endmodule

// File: tb/tb_dec_to_xs3_key_encoder.sv
// Self-checking bench for dec_to_xs3_key_encoder: directed keystroke
// scenarios with literal expectations plus randomized key/handshake traffic
// checked every cycle against a run-length behavioural model.
module tb_dec_to_xs3_key_encoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] i_n = '1;
  logic       ready = 1'b1;
  logic [3:0] q;
  logic       valid, ovf, busy;

  dec_to_xs3_key_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK   (clk),
    .RST   (rst),
    .I_N   (i_n),
    .Q     (q),
    .VALID (valid),
    .READY (ready),
    .OVF   (ovf),
    .BUSY  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is a run of DC identical samples of one key
  // while armed; a release is a run of DC key-free samples while held.
  logic [9:0] m_sync1 = '1, m_sync2 = '1;
  int         m_last = -1;
  int         m_run = 0;
  bit         m_armed = 1'b1;
  logic [3:0] m_q = 4'd0;
  bit         m_valid = 1'b0, m_ovf = 1'b0, m_busy = 1'b0;

  function automatic int top_key(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) if (!s[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int c;
    bit acc;
    if (rst) begin
      m_sync1 = '1; m_sync2 = '1;
      m_last = -1; m_run = 0; m_armed = 1'b1;
      m_q = 4'd0; m_valid = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
    end else begin
      c = top_key(m_sync2);
      m_sync2 = m_sync1;
      m_sync1 = i_n;
      if (c == m_last) m_run++; else m_run = 1;
      m_last = c;
      acc = 1'b0;
      if (m_armed) begin
        if (c >= 0 && m_run == DC) begin
          acc = 1'b1;
          m_armed = 1'b0;
        end
      end else if (c < 0 && m_run == DC) begin
        m_armed = 1'b1;
      end
      if (acc) begin
        if (!m_valid || ready) begin
          m_q = 4'(c + 3);
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      m_busy = !m_armed || (c >= 0);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_q",     32'(q),     32'(m_q));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_ovf",   32'(ovf),   32'(m_ovf));
      chk("model_busy",  32'(busy),  32'(m_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] one_low(input int k);
    logic [9:0] v;
    v = '1;
    v[k] = 1'b0;
    return v;
  endfunction

  initial begin
    int kind;
    int len;
    rst = 1'b1; i_n = '1; ready = 1'b1;
    cyc(2);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single key 7: VALID after the sixth edge, one code only.
    i_n = one_low(7);
    cyc(5); chk("k7_early_valid", 32'(valid), 32'h0);
    cyc(1); chk("k7_valid", 32'(valid), 32'h1); chk("k7_q", 32'(q), 32'hA);
    cyc(1); chk("k7_drop", 32'(valid), 32'h0);
    cyc(20); chk("k7_no_repeat", 32'(valid), 32'h0); chk("k7_busy_held", 32'(busy), 32'h1);
    i_n = '1;
    cyc(5); chk("k7_rel_busy", 32'(busy), 32'h1);
    cyc(1); chk("k7_idle", 32'(busy), 32'h0);

    // Keys 2 and 9 together: 9 wins.
    i_n = '1; i_n[2] = 1'b0; i_n[9] = 1'b0;
    cyc(6); chk("prio_valid", 32'(valid), 32'h1); chk("prio_q", 32'(q), 32'hC);
    i_n = '1; cyc(8);

    // Bouncing key 4 never settles long enough.
    for (int r = 0; r < 4; r++) begin
      i_n = one_low(4); cyc(3);
      i_n = '1; cyc(1);
    end
    cyc(6);
    chk("bounce_no_valid", 32'(valid), 32'h0);
    chk("bounce_q_kept", 32'(q), 32'hC);
    chk("bounce_idle", 32'(busy), 32'h0);
    i_n = one_low(4);
    cyc(6); chk("k4_valid", 32'(valid), 32'h1); chk("k4_q", 32'(q), 32'h7);
    i_n = '1; cyc(8);

    // Overflow: second press while the first code is still pending.
    ready = 1'b0;
    i_n = one_low(0);
    cyc(6); chk("ovf_k0_q", 32'(q), 32'h3); chk("ovf_k0_valid", 32'(valid), 32'h1);
    chk("ovf_clear", 32'(ovf), 32'h0);
    i_n = '1; cyc(8);
    i_n = one_low(5);
    cyc(6); chk("ovf_q_kept", 32'(q), 32'h3); chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_valid_held", 32'(valid), 32'h1);
    ready = 1'b1;
    cyc(1); chk("ovf_xfer", 32'(valid), 32'h0); chk("ovf_sticky", 32'(ovf), 32'h1);
    cyc(3); chk("ovf_no_second", 32'(valid), 32'h0);
    i_n = '1; cyc(8);

    // Back-to-back: accept of key 1 coincides with transfer of key 8.
    ready = 1'b0;
    i_n = one_low(8);
    cyc(6); chk("b2b_k8_q", 32'(q), 32'hB); chk("b2b_k8_valid", 32'(valid), 32'h1);
    i_n = '1; cyc(8);
    i_n = one_low(1);
    cyc(5); chk("b2b_pending", 32'(q), 32'hB);
    ready = 1'b1;
    cyc(1); chk("b2b_valid", 32'(valid), 32'h1); chk("b2b_q", 32'(q), 32'h4);
    cyc(1); chk("b2b_drop", 32'(valid), 32'h0);
    i_n = '1; cyc(8);

    // Reset during debounce with the key still held.
    i_n = one_low(6);
    cyc(3); chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    cyc(1); chk("mid_rst_busy", 32'(busy), 32'h0); chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    cyc(5); chk("mid_early", 32'(valid), 32'h0);
    cyc(1); chk("mid_valid", 32'(valid), 32'h1); chk("mid_q", 32'(q), 32'h9);
    i_n = '1; cyc(8);

    // Randomized key patterns, glitches, backpressure and occasional reset.
    for (int s = 0; s < 400; s++) begin
      kind = int'($urandom_range(0, 4));
      len  = int'($urandom_range(1, 12));
      case (kind)
        0: i_n = '1;
        1, 2: i_n = one_low(int'($urandom_range(0, 9)));
        3: i_n = 10'($urandom);
        default: i_n[$urandom_range(0, 9)] = ~i_n[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
      for (int c = 0; c < len; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        cyc(1);
        rst = 1'b0;
      end
    end
    i_n = '1; ready = 1'b1;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
